// File: rtl/ipd_sample_sequencer.sv
// Sample-period sequencer for the pipelined IPD control law: tick, ADC fetch, fill, update, settle, publish.
// Optional ADC wait timeout is enabled by defining IPD_SEQ_TIMEOUT_EN.
module ipd_sample_sequencer #(
    parameter int unsigned       Width     = 19,
    parameter int unsigned       DivWidth  = 16,
    parameter int unsigned       Latencia  = 4,
    parameter logic [Width-1:0]  SatMax    = 19'h0FFFF,
    parameter logic [Width-1:0]  SatMin    = 19'h70000,
    parameter int unsigned       TimeoutCy = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [DivWidth-1:0] divisor,
    output logic                adc_req,
    input  logic                adc_valid,
    input  logic [Width-1:0]    adc_data,
    output logic [Width-1:0]    y_k,
    output logic                ipd_enable,
    input  logic [Width-1:0]    salida_IPD,
    output logic [Width-1:0]    u_k,
    output logic                u_valid,
    output logic                busy,
    output logic                overrun,
    output logic                adc_timeout
);

    localparam int unsigned LatW = (Latencia < 2) ? 1 : $clog2(Latencia);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_REQ, S_FILL, S_UPDATE, S_SETTLE, S_OUTPUT
    } state_t;

    state_t              state;
    logic [DivWidth-1:0] cnt;
    logic [DivWidth-1:0] term;
    logic [DivWidth-1:0] term_next;
    logic [LatW-1:0]     lat_cnt;
    logic                tick;
    logic                stop_lat;
    logic                to_hit;

    function automatic logic [Width-1:0] sat(input logic [Width-1:0] x);
        if ($signed(x) > $signed(SatMax))
            return SatMax;
        else if ($signed(x) < $signed(SatMin))
            return SatMin;
        else
            return x;
    endfunction

    // A zero divisor behaves as 1, so the terminal count is 0 in both cases.
    assign term_next = (divisor == '0) ? '0 : divisor - DivWidth'(1);
    assign tick      = (state != S_IDLE) && (cnt == term);
    assign busy      = (state != S_IDLE) && (state != S_WAIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            term <= '0;
        end else if (state == S_IDLE || tick) begin
            cnt  <= '0;
            term <= term_next;
        end else begin
            cnt  <= cnt + DivWidth'(1);
        end
    end

`ifdef IPD_SEQ_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TimeoutCy + 1);
    logic [ToW-1:0] to_cnt;

    assign to_hit = (state == S_REQ) && !adc_valid && (to_cnt == ToW'(TimeoutCy - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt      <= '0;
            adc_timeout <= 1'b0;
        end else if (state != S_REQ) begin
            to_cnt      <= '0;
        end else if (to_hit) begin
            to_cnt      <= '0;
            adc_timeout <= 1'b1;
        end else if (!adc_valid) begin
            to_cnt      <= to_cnt + ToW'(1);
        end
    end
`else
    assign to_hit      = 1'b0;
    assign adc_timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            adc_req    <= 1'b0;
            y_k        <= '0;
            ipd_enable <= 1'b0;
            u_k        <= '0;
            u_valid    <= 1'b0;
            overrun    <= 1'b0;
            stop_lat   <= 1'b0;
            lat_cnt    <= '0;
        end else begin
            ipd_enable <= 1'b0;
            u_valid    <= 1'b0;
            if (stop)
                stop_lat <= 1'b1;
            // Ticks are only consumed in WAIT; anywhere else in a sample they are lost.
            if (tick && busy)
                overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    stop_lat <= 1'b0;
                    if (start && !stop)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (stop_lat) begin
                        stop_lat <= 1'b0;
                        state    <= S_IDLE;
                    end else if (tick) begin
                        adc_req  <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (adc_valid) begin
                        y_k     <= adc_data;
                        adc_req <= 1'b0;
                        lat_cnt <= '0;
                        state   <= S_FILL;
                    end else if (to_hit) begin
                        adc_req <= 1'b0;
                        lat_cnt <= '0;
                        state   <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (lat_cnt == LatW'(Latencia - 1)) begin
                        ipd_enable <= 1'b1;
                        state      <= S_UPDATE;
                    end else begin
                        lat_cnt    <= lat_cnt + LatW'(1);
                    end
                end
                S_UPDATE: begin
                    lat_cnt <= '0;
                    state   <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (lat_cnt == LatW'(Latencia - 1)) begin
                        u_k     <= sat(salida_IPD);
                        u_valid <= 1'b1;
                        state   <= S_OUTPUT;
                    end else begin
                        lat_cnt <= lat_cnt + LatW'(1);
                    end
                end
                S_OUTPUT: begin
                    if (stop_lat) begin
                        stop_lat <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        state    <= S_WAIT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ipd_sample_sequencer.sv
// Directed bench for ipd_sample_sequencer: saturation vector table plus multi-cycle sequences.
// Timeout checks follow IPD_SEQ_TIMEOUT_EN when it is defined for the build.
module tb_ipd_sample_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [15:0] divisor;
    logic        adc_req;
    logic        adc_valid;
    logic [18:0] adc_data;
    logic [18:0] y_k;
    logic        ipd_enable;
    logic [18:0] salida_IPD;
    logic [18:0] u_k;
    logic        u_valid;
    logic        busy;
    logic        overrun;
    logic        adc_timeout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [18:0] salida;
        logic [18:0] exp_u;
    } sat_vec_t;

    sat_vec_t vecs[9];

    ipd_sample_sequencer #(
        .Width(19), .DivWidth(16), .Latencia(4),
        .SatMax(19'h0FFFF), .SatMin(19'h70000), .TimeoutCy(64)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop), .divisor(divisor),
        .adc_req(adc_req), .adc_valid(adc_valid), .adc_data(adc_data), .y_k(y_k),
        .ipd_enable(ipd_enable), .salida_IPD(salida_IPD), .u_k(u_k), .u_valid(u_valid),
        .busy(busy), .overrun(overrun), .adc_timeout(adc_timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
    endtask

    task automatic wait_uvalid(input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (u_valid) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        check(name, ok, 1'b1);
    endtask

    task automatic wait_req(input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (adc_req) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        check(name, ok, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first_req, second_req, en_n, en_at, uv_n, uv_at, req_rises, k;
        logic [18:0] yk_cap, uk_cap;
        logic prev_req, ov10, ov11;

        vecs[0] = '{19'h1FFFF, 19'h0FFFF};
        vecs[1] = '{19'h40000, 19'h70000};
        vecs[2] = '{19'h00123, 19'h00123};
        vecs[3] = '{19'h0FFFF, 19'h0FFFF};
        vecs[4] = '{19'h10000, 19'h0FFFF};
        vecs[5] = '{19'h70000, 19'h70000};
        vecs[6] = '{19'h6FFFF, 19'h70000};
        vecs[7] = '{19'h7FFFF, 19'h7FFFF};
        vecs[8] = '{19'h00000, 19'h00000};

        divisor    = 16'd20;
        adc_valid  = 1'b1;
        adc_data   = 19'd100;
        salida_IPD = 19'h00123;
        cyc();
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) cyc();
        check("rst_adc_req", adc_req, 0);
        check("rst_y_k", y_k, 0);
        check("rst_ipd_enable", ipd_enable, 0);
        check("rst_u_k", u_k, 0);
        check("rst_u_valid", u_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_adc_timeout", adc_timeout, 0);
        reset = 1'b1;
        cyc();

        // Basic sample: divisor 20, ADC ready at request.
        pulse_start();
        first_req = -1; second_req = -1; en_n = 0; en_at = -1; uv_n = 0; uv_at = -1;
        prev_req = 1'b0; yk_cap = '0; uk_cap = '0;
        for (int c = 1; c <= 45; c++) begin
            if (adc_req && !prev_req) begin
                if (first_req < 0) first_req = c;
                else if (second_req < 0) second_req = c;
            end
            prev_req = adc_req;
            if (ipd_enable) begin
                en_n++;
                if (en_at < 0) en_at = c;
            end
            if (u_valid) begin
                uv_n++;
                if (uv_at < 0) begin
                    uv_at  = c;
                    uk_cap = u_k;
                end
            end
            if (c == 22) yk_cap = y_k;
            cyc();
        end
        check("first_req_cycle", first_req, 21);
        check("y_k_captured", yk_cap, 19'd100);
        check("ipd_enable_at", en_at, 26);
        check("ipd_enable_count", en_n, 1);
        check("tick_to_uvalid", uv_at - first_req + 1, 11);
        check("uvalid_count", uv_n, 1);
        check("u_k_passthru", uk_cap, 19'h00123);
        check("period", second_req - first_req, 20);

        pulse_stop();
        req_rises = 0;
        prev_req  = adc_req;
        for (int c = 0; c < 40; c++) begin
            if (adc_req && !prev_req) req_rises++;
            prev_req = adc_req;
            cyc();
        end
        check("stop_no_req", req_rises, 0);
        check("stop_idle_busy", busy, 0);

        // Saturation vectors, one sample each from IDLE.
        for (int i = 0; i < 9; i++) begin
            salida_IPD = vecs[i].salida;
            pulse_start();
            wait_uvalid("sat_uvalid_seen");
            check($sformatf("sat_u_k[%0d]", i), u_k, vecs[i].exp_u);
            pulse_stop();
            cyc();
            check($sformatf("sat_idle[%0d]", i), busy, 0);
        end

        // Overrun with divisor shorter than the sample latency.
        do_reset();
        divisor    = 16'd5;
        salida_IPD = 19'h00010;
        pulse_start();
        en_n = 0; uv_n = 0; ov10 = 1'b1; ov11 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (ipd_enable) en_n++;
            if (u_valid) uv_n++;
            if (c == 10) ov10 = overrun;
            if (c == 11) ov11 = overrun;
            cyc();
        end
        check("ovr_before_2nd_tick", ov10, 0);
        check("ovr_after_2nd_tick", ov11, 1);
        check("ovr_enable_count", en_n, 2);
        check("ovr_uvalid_count", uv_n, 2);
        pulse_stop();
        repeat (30) cyc();
        check("ovr_sticky", overrun, 1);
        check("ovr_stopped", adc_req | busy, 0);

        // Stop during FILL: sample still completes once.
        divisor    = 16'd20;
        salida_IPD = 19'h00055;
        pulse_start();
        wait_req("fill_req_seen");
        cyc();
        check("fill_req_dropped", adc_req, 0);
        pulse_stop();
        uv_n = 0; req_rises = 0; prev_req = adc_req;
        for (int c = 0; c < 50; c++) begin
            if (u_valid) begin
                uv_n++;
                uk_cap = u_k;
            end
            if (adc_req && !prev_req) req_rises++;
            prev_req = adc_req;
            cyc();
        end
        check("fill_stop_uvalid", uv_n, 1);
        check("fill_stop_u_k", uk_cap, 19'h00055);
        check("fill_stop_no_req", req_rises, 0);
        check("fill_stop_idle", busy, 0);

        // Asynchronous reset during SETTLE.
        pulse_start();
        for (int n = 0; n < 40 && !ipd_enable; n++) cyc();
        check("settle_enable_seen", ipd_enable, 1);
        repeat (2) cyc();
        check("settle_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("arst_outputs", {adc_req, ipd_enable, u_valid, busy, overrun}, 0);
        check("arst_y_k", y_k, 0);
        check("arst_u_k", u_k, 0);
        cyc();
        reset = 1'b1;
        cyc();
        adc_data = 19'd100;
        pulse_start();
        first_req = -1;
        for (int c = 1; c <= 30; c++) begin
            if (adc_req && first_req < 0) first_req = c;
            cyc();
        end
        check("restart_first_req", first_req, 21);
        wait_uvalid("restart_uvalid_seen");
        check("restart_u_k", u_k, 19'h00055);
        check("restart_y_k", y_k, 19'd100);

        // ADC stall: timeout behaviour depends on the build.
        adc_valid = 1'b0;
        adc_data  = 19'd55;
        cyc();
        wait_req("stall_req_seen");
        k = 0;
        while (adc_req && k < 100) begin
            k++;
            cyc();
        end
`ifdef IPD_SEQ_TIMEOUT_EN
        check("timeout_req_cycles", k, 64);
        check("timeout_flag", adc_timeout, 1);
        check("timeout_y_k_kept", y_k, 19'd100);
        wait_uvalid("timeout_uvalid_seen");
`else
        check("stall_req_held", k, 100);
        check("stall_no_timeout", adc_timeout, 0);
        check("stall_y_k_kept", y_k, 19'd100);
        adc_valid = 1'b1;
        cyc();
        check("stall_y_k_new", y_k, 19'd55);
        check("stall_req_dropped", adc_req, 0);
        wait_uvalid("stall_uvalid_seen");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
